usb_rx_nrzi_decoder: RTL

//  Receive-side counterpart of the USB full-speed NRZI transmit encoder. Samples the
//  D+/D- pins with an oversampled clock and resyncs bit timing on every data edge.

---
 rtl/usb_rx_pkg.sv | 18 +
 rtl/usb_rx_bit_timer.sv | 32 +++
 rtl/usb_rx_nrzi_decoder.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/usb_rx_pkg.sv
// rtl/usb_rx_pkg.sv - shared FSM states, stuffing limit and line-state encodings for the USB receiver
package usb_rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        EOP1   = 2'd2,
        EOP2   = 2'd3
    } rx_state_t;

    localparam int STUFF_LIMIT = 6;

    // Line states as {dp, dm}, identical to the transmit encoder's view of the bus
    localparam logic [1:0] LS_J   = 2'b10;
    localparam logic [1:0] LS_K   = 2'b01;
    localparam logic [1:0] LS_SE0 = 2'b00;

endpackage

// File: rtl/usb_rx_bit_timer.sv
// rtl/usb_rx_bit_timer.sv - bit-period timer that re-aligns on data edges and marks the sample point
module usb_rx_bit_timer #(
    parameter int CLKS_PER_BIT = 8,
    parameter int SAMPLE_PT    = 4
) (
    input  logic clk,
    input  logic n_rst,
    input  logic enable,
    input  logic resync,
    output logic sample_strobe
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] LAST   = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] SAMPLE = TW'(SAMPLE_PT);

    logic [TW-1:0] timer;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            timer <= '0;
        end else if (!enable || resync || timer == LAST) begin
            timer <= '0;
        end else begin
            timer <= timer + TW'(1);
        end
    end

    // An edge landing on the sample point restarts the period instead of sampling
    assign sample_strobe = enable && !resync && (timer == SAMPLE);

endmodule

// File: rtl/usb_rx_nrzi_decoder.sv
// rtl/usb_rx_nrzi_decoder.sv - USB FS receive NRZI decoder, bit unstuffer and EOP detector; RX_STUFF_CHECK_EN enables stuff-error abort
module usb_rx_nrzi_decoder
    import usb_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int SAMPLE_PT    = 4
) (
    input  logic clk,
    input  logic n_rst,
    input  logic d_plus_in,
    input  logic d_minus_in,
    output logic rx_bit,
    output logic rx_bit_valid,
    output logic rx_active,
    output logic eop_det,
    output logic stuff_err
);

    localparam logic [2:0] STUFF_LIM = 3'(STUFF_LIMIT);
    localparam logic [2:0] ONES_MAX  = 3'd7;

    logic dp_meta, dp_s, dm_meta, dm_s, dp_prev;
    logic data_edge, se0, sample, nrzi_bit;

    rx_state_t  state, state_nxt;
    logic [2:0] ones_cnt, ones_nxt;
    logic       prev_level, prev_nxt;
    logic       bit_nxt, valid_nxt, eop_nxt, err_nxt;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dp_meta <= 1'b1;
            dp_s    <= 1'b1;
            dm_meta <= 1'b0;
            dm_s    <= 1'b0;
            dp_prev <= 1'b1;
        end else begin
            dp_meta <= d_plus_in;
            dp_s    <= dp_meta;
            dm_meta <= d_minus_in;
            dm_s    <= dm_meta;
            dp_prev <= dp_s;
        end
    end

    assign data_edge = dp_s ^ dp_prev;
    assign se0       = ({dp_s, dm_s} == LS_SE0);
    assign nrzi_bit  = (dp_s == prev_level);

    usb_rx_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .SAMPLE_PT    (SAMPLE_PT)
    ) u_bit_timer (
        .clk           (clk),
        .n_rst         (n_rst),
        .enable        (state != IDLE),
        .resync        (data_edge),
        .sample_strobe (sample)
    );

    always_comb begin
        state_nxt = state;
        ones_nxt  = ones_cnt;
        prev_nxt  = prev_level;
        bit_nxt   = 1'b0;
        valid_nxt = 1'b0;
        eop_nxt   = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (data_edge && !dp_s && !se0) begin
                    state_nxt = ACTIVE;
                    prev_nxt  = 1'b1;
                    ones_nxt  = '0;
                end
            end
            ACTIVE: begin
                if (sample) begin
                    if (se0) begin
                        state_nxt = EOP1;
                    end else begin
                        prev_nxt = dp_s;
                        if (ones_cnt == STUFF_LIM && !nrzi_bit) begin
                            ones_nxt = '0;
`ifdef RX_STUFF_CHECK_EN
                        end else if (ones_cnt == STUFF_LIM) begin
                            err_nxt   = 1'b1;
                            state_nxt = IDLE;
`endif
                        end else begin
                            valid_nxt = 1'b1;
                            bit_nxt   = nrzi_bit;
                            if (!nrzi_bit) begin
                                ones_nxt = '0;
                            end else if (ones_cnt != ONES_MAX) begin
                                ones_nxt = ones_cnt + 3'd1;
                            end
                        end
                    end
                end
            end
            EOP1: begin
                if (sample) begin
                    state_nxt = se0 ? EOP2 : IDLE;
                end
            end
            EOP2: begin
                // SE1 reads as its dp level, so it completes the EOP like J
                if (sample && !se0) begin
                    eop_nxt   = dp_s;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= IDLE;
            ones_cnt     <= '0;
            prev_level   <= 1'b1;
            rx_bit       <= 1'b0;
            rx_bit_valid <= 1'b0;
            eop_det      <= 1'b0;
            stuff_err    <= 1'b0;
        end else begin
            state        <= state_nxt;
            ones_cnt     <= ones_nxt;
            prev_level   <= prev_nxt;
            rx_bit       <= bit_nxt;
            rx_bit_valid <= valid_nxt;
            eop_det      <= eop_nxt;
            stuff_err    <= err_nxt;
        end
    end

    assign rx_active = (state != IDLE);

endmodule
